// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Shares a single-operation-per-cycle register file between one writeback
//   write port (wb) and two read ports (rd0 = decode, rd1 = debug/aux).
//   At most one of rf_we / rf_re is raised per cycle. Read data returns one
//   cycle after the grant, straight from the register file's latched outputs,
//   tagged with the winning reader.
//   Priority: wb wins unless it has already taken WR_STREAK_MAX grants in a row
//   while a read was waiting. rd0/rd1 alternate round-robin.
// Ports
//   clk, rst                         clock, async active-high reset
//   wb_valid/ready, wb_addr/data     write requester
//   rd0_valid/ready, rd0_addr_a/b    read requester 0 (rsp_id 0)
//   rd1_valid/ready, rd1_addr_a/b    read requester 1 (rsp_id 1)
//   rsp_valid, rsp_id, rsp_data_a/b  read response, valid the cycle after grant
//   rf_we/re, rf_regW/dataIn/regA/B  register file command
//   rf_outA/B                        register file latched read data
module regfile_port_arbiter #(
   parameter int unsigned WR_STREAK_MAX = 4,
   parameter int unsigned STREAK_W      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        rd0_valid,
   output logic        rd0_ready,
   input  logic [4:0]  rd0_addr_a,
   input  logic [4:0]  rd0_addr_b,
   input  logic        rd1_valid,
   output logic        rd1_ready,
   input  logic [4:0]  rd1_addr_a,
   input  logic [4:0]  rd1_addr_b,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_data_a,
   output logic [31:0] rsp_data_b,
   output logic        rf_we,
   output logic        rf_re,
   output logic [4:0]  rf_regW,
   output logic [31:0] rf_dataIn,
   output logic [4:0]  rf_regA,
   output logic [4:0]  rf_regB,
   input  logic [31:0] rf_outA,
   input  logic [31:0] rf_outB
);

   localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(WR_STREAK_MAX);

   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                rr_q, rr_d;     // preferred reader: 0 = rd0, 1 = rd1
   logic                rd_any, force_rd, grant_wb, grant_rd, rd_win;

   always_comb begin
      rd_any   = rd0_valid | rd1_valid;
      force_rd = rd_any & (streak_q == StreakMax);
      // Readies are forced low while reset is held, even though they are combinational.
      grant_wb = ~rst & wb_valid & ~force_rd;
      grant_rd = ~rst & ~grant_wb & rd_any;
      // Preferred reader if it is asking, otherwise whichever one is.
      rd_win   = rr_q ? rd1_valid : ~rd0_valid;
   end

   always_comb begin
      wb_ready  = grant_wb;
      rd0_ready = grant_rd & ~rd_win;
      rd1_ready = grant_rd & rd_win;
      rf_we     = grant_wb;
      rf_re     = grant_rd;
      rf_regW   = grant_wb ? wb_addr : 5'd0;
      rf_dataIn = grant_wb ? wb_data : 32'd0;
      rf_regA   = 5'd0;
      rf_regB   = 5'd0;
      if (grant_rd) begin
         rf_regA = rd_win ? rd1_addr_a : rd0_addr_a;
         rf_regB = rd_win ? rd1_addr_b : rd0_addr_b;
      end
      rsp_data_a = rf_outA;
      rsp_data_b = rf_outB;
   end

   always_comb begin
      streak_d = streak_q;
      if (grant_rd || !rd_any) begin
         streak_d = '0;
      end else if (grant_wb && (streak_q != StreakMax)) begin
         streak_d = streak_q + 1'b1;
      end
      rr_d = grant_rd ? ~rd_win : rr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_q  <= '0;
         rr_q      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
      end else begin
         streak_q  <= streak_d;
         rr_q      <= rr_d;
         rsp_valid <= grant_rd;
         if (grant_rd) begin
            rsp_id <= rd_win;
         end
      end
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
//   Directed scenarios followed by randomized traffic. Each cycle the expected
//   grant, register file command and read response are predicted from the
//   arbitration rules and a shadow copy of the register contents.
module tb_regfile_port_arbiter;

   localparam int unsigned MaxStreak = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_valid, wb_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        rd0_valid, rd0_ready;
   logic [4:0]  rd0_addr_a, rd0_addr_b;
   logic        rd1_valid, rd1_ready;
   logic [4:0]  rd1_addr_a, rd1_addr_b;
   logic        rsp_valid, rsp_id;
   logic [31:0] rsp_data_a, rsp_data_b;
   logic        rf_we, rf_re;
   logic [4:0]  rf_regW, rf_regA, rf_regB;
   logic [31:0] rf_dataIn, rf_outA, rf_outB;

   always #5 clk = ~clk;

   regfile_port_arbiter #(
      .WR_STREAK_MAX (MaxStreak),
      .STREAK_W      (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .rd0_valid  (rd0_valid),
      .rd0_ready  (rd0_ready),
      .rd0_addr_a (rd0_addr_a),
      .rd0_addr_b (rd0_addr_b),
      .rd1_valid  (rd1_valid),
      .rd1_ready  (rd1_ready),
      .rd1_addr_a (rd1_addr_a),
      .rd1_addr_b (rd1_addr_b),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data_a (rsp_data_a),
      .rsp_data_b (rsp_data_b),
      .rf_we      (rf_we),
      .rf_re      (rf_re),
      .rf_regW    (rf_regW),
      .rf_dataIn  (rf_dataIn),
      .rf_regA    (rf_regA),
      .rf_regB    (rf_regB),
      .rf_outA    (rf_outA),
      .rf_outB    (rf_outB)
   );

   function automatic logic [31:0] init_val(input int i);
      return (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   // Register file stand-in: latched read outputs, reg 0 hardwired to zero.
   logic [31:0] rf_mem [32];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
         rf_outA <= 32'd0;
         rf_outB <= 32'd0;
      end else begin
         if (rf_we && rf_regW != 5'd0) rf_mem[rf_regW] <= rf_dataIn;
         if (rf_re) begin
            rf_outA <= (rf_regA == 5'd0) ? 32'd0 : rf_mem[rf_regA];
            rf_outB <= (rf_regB == 5'd0) ? 32'd0 : rf_mem[rf_regB];
         end
      end
   end

   // Reference model state
   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_streak;
   int          m_rr;
   bit          exp_vld;
   bit          exp_id;
   logic [31:0] exp_a, exp_b;
   logic [31:0] ref_mem [32];
   bit          last_gwb, last_grd;
   int          last_win;
   bit          last_dut_rd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_streak = 0;
      m_rr     = 0;
      exp_vld  = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
   endtask

   // Called just after a posedge with inputs already applied; checks this
   // cycle's outputs, advances the model and returns just after the next posedge.
   task automatic step();
      bit rd_any, frc, gwb, grd;
      int win;
      logic [4:0]  e_ra, e_rb, e_rw;
      logic [31:0] e_din;
      #1;
      rd_any = rd0_valid || rd1_valid;
      frc    = rd_any && (m_streak == MaxStreak);
      gwb    = wb_valid && !frc;
      grd    = !gwb && rd_any;
      if (m_rr == 0) win = rd0_valid ? 0 : 1;
      else           win = rd1_valid ? 1 : 0;
      e_rw  = gwb ? wb_addr : 5'd0;
      e_din = gwb ? wb_data : 32'd0;
      e_ra  = grd ? ((win == 1) ? rd1_addr_a : rd0_addr_a) : 5'd0;
      e_rb  = grd ? ((win == 1) ? rd1_addr_b : rd0_addr_b) : 5'd0;

      check("wb_ready",  32'(wb_ready),  32'(gwb));
      check("rd0_ready", 32'(rd0_ready), 32'(grd && win == 0));
      check("rd1_ready", 32'(rd1_ready), 32'(grd && win == 1));
      check("rf_we",     32'(rf_we),     32'(gwb));
      check("rf_re",     32'(rf_re),     32'(grd));
      check("rf_regW",   32'(rf_regW),   32'(e_rw));
      check("rf_dataIn", rf_dataIn,      e_din);
      check("rf_regA",   32'(rf_regA),   32'(e_ra));
      check("rf_regB",   32'(rf_regB),   32'(e_rb));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
      if (exp_vld) begin
         check("rsp_id",     32'(rsp_id), 32'(exp_id));
         check("rsp_data_a", rsp_data_a,  exp_a);
         check("rsp_data_b", rsp_data_b,  exp_b);
      end
      last_dut_rd1 = rd1_ready;

      if (gwb) begin
         if (wb_addr != 5'd0) ref_mem[wb_addr] = wb_data;
         m_streak = rd_any ? ((m_streak < MaxStreak) ? m_streak + 1 : MaxStreak) : 0;
      end else begin
         m_streak = 0;
      end
      exp_vld = grd;
      if (grd) begin
         exp_id = (win == 1);
         exp_a  = ref_mem[e_ra];
         exp_b  = ref_mem[e_rb];
         m_rr   = 1 - win;
      end
      last_gwb = gwb;
      last_grd = grd;
      last_win = win;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_valid  = 1'b0;
      rd0_valid = 1'b0;
      rd1_valid = 1'b0;
   endtask

   int rd1_grants;

   initial begin
      idle();
      wb_addr = 5'd0;  wb_data = 32'd0;
      rd0_addr_a = 5'd0; rd0_addr_b = 5'd0;
      rd1_addr_a = 5'd0; rd1_addr_b = 5'd0;
      model_reset();

      // Reset state: requests present while reset is held must not be granted.
      wb_valid = 1'b1; rd0_valid = 1'b1; rd1_valid = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("rst_wb_ready",  32'(wb_ready),  32'd0);
      check("rst_rd0_ready", 32'(rd0_ready), 32'd0);
      check("rst_rd1_ready", 32'(rd1_ready), 32'd0);
      check("rst_rf_we",     32'(rf_we),     32'd0);
      check("rst_rf_re",     32'(rf_re),     32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      idle();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Write then read back through rd0.
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
      step();
      wb_valid = 1'b0;
      rd0_valid = 1'b1; rd0_addr_a = 5'd5; rd0_addr_b = 5'd0;
      step();
      rd0_valid = 1'b0;
      check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t2_rsp_id",    32'(rsp_id),    32'd0);
      check("t2_rsp_a",     rsp_data_a,     32'hDEAD_BEEF);
      check("t2_rsp_b",     rsp_data_b,     32'd0);
      step();

      // Both readers continuously: alternating grants.
      rd0_valid = 1'b1; rd0_addr_a = 5'd1; rd0_addr_b = 5'd2;
      rd1_valid = 1'b1; rd1_addr_a = 5'd3; rd1_addr_b = 5'd4;
      repeat (8) step();
      idle();
      step();

      // Writer continuously against rd1: four writes, then one read, repeating.
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0009;
      rd1_valid = 1'b1; rd1_addr_a = 5'd9; rd1_addr_b = 5'd8;
      rd1_grants = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (last_dut_rd1) rd1_grants++;
         wb_data = wb_data + 32'd1;
      end
      check("t4_rd1_grants", 32'(rd1_grants), 32'd3);
      idle();
      step();

      // Read-before-write ordering on reg 7.
      rd0_valid = 1'b1; rd0_addr_a = 5'd7; rd0_addr_b = 5'd0;
      step();
      rd0_valid = 1'b0;
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0001;
      check("t5_old_value", rsp_data_a, init_val(7));
      step();
      wb_valid = 1'b0;
      rd0_valid = 1'b1;
      step();
      rd0_valid = 1'b0;
      check("t5_new_value", rsp_data_a, 32'h0000_0001);
      step();

      // A write to reg 0 is consumed but has no effect.
      wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
      #1;
      check("t6_wb_ready", 32'(wb_ready), 32'd1);
      step();
      wb_valid = 1'b0;
      rd0_valid = 1'b1; rd0_addr_a = 5'd0; rd0_addr_b = 5'd0;
      step();
      rd0_valid = 1'b0;
      check("t6_rsp_a", rsp_data_a, 32'd0);

      // Reset in the response cycle of an rd1 read drops the response.
      rd1_valid = 1'b1; rd1_addr_a = 5'd3; rd1_addr_b = 5'd4;
      step();
      wb_valid = 1'b1; rd0_valid = 1'b1;
      rst = 1'b1;
      #1;
      check("t1_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t1_rsp_id",    32'(rsp_id),    32'd0);
      check("t1_wb_ready",  32'(wb_ready),  32'd0);
      check("t1_rd0_ready", 32'(rd0_ready), 32'd0);
      check("t1_rd1_ready", 32'(rd1_ready), 32'd0);
      check("t1_rf_we",     32'(rf_we),     32'd0);
      check("t1_rf_re",     32'(rf_re),     32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      wb_valid = 1'b0;
      step();
      idle();

      // Random traffic; each requester holds its request until granted.
      for (int c = 0; c < 3000; c++) begin
         if (!wb_valid && $urandom_range(0, 99) < 70) begin
            wb_valid = 1'b1;
            wb_addr  = 5'($urandom_range(0, 31));
            wb_data  = $urandom;
         end
         if (!rd0_valid && $urandom_range(0, 99) < 40) begin
            rd0_valid  = 1'b1;
            rd0_addr_a = 5'($urandom_range(0, 31));
            rd0_addr_b = 5'($urandom_range(0, 31));
         end
         if (!rd1_valid && $urandom_range(0, 99) < 40) begin
            rd1_valid  = 1'b1;
            rd1_addr_a = 5'($urandom_range(0, 31));
            rd1_addr_b = 5'($urandom_range(0, 31));
         end
         step();
         if (last_gwb) wb_valid = 1'b0;
         if (last_grd && last_win == 0) rd0_valid = 1'b0;
         if (last_grd && last_win == 1) rd1_valid = 1'b0;
      end
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
